// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin select arbiter.
// Select encoding follows the {s1,s2} mux pair: 00=a, 01=b, 10=c, 11=d.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  function automatic logic [NUM_REQ-1:0] sel2onehot(input sel_t sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr, wrapping mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);

  sel_t w_cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = sel_t'(ptr + sel_t'(k));
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the shared 4-to-1 select pair with a valid/ready output.
// Optional MUX_ARB_LOCK_EN adds a per-requester lock input that holds the grant for up to MAX_LOCK transfers.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  input  logic [WIDTH-1:0]     data_c,
  input  logic [WIDTH-1:0]     data_d,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lock,
`endif
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 s1,
  output logic                 s2,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready
);

  if (MAX_LOCK < 1) begin : g_badMaxLock
    $error("mux_rr_arbiter: MAX_LOCK must be at least 1");
  end

  arb_state_t          r_state;
  sel_t                r_ptr;
  sel_t                r_sel;
  logic [NUM_REQ-1:0]  r_gnt;

  logic                w_valid;
  logic                w_xfer;
  logic                w_stall;
  logic                w_keep;
  logic [NUM_REQ-1:0]  w_others;
  logic [NUM_REQ-1:0]  w_pickReq;
  sel_t                w_pickPtr;
  logic                w_found;
  sel_t                w_idx;
  logic [WIDTH-1:0]    w_data;

  assign w_valid = (r_state == GRANT) && req[r_sel];
  assign w_xfer  = w_valid && out_ready;
  assign w_stall = w_valid && !out_ready;

  // After a transfer the current holder is masked out unless it is the only requester left.
  assign w_others  = req & ~sel2onehot(r_sel);
  assign w_pickReq = (r_state == GRANT) ? ((w_others != '0) ? w_others : req) : req;
  assign w_pickPtr = (r_state == GRANT) ? sel_t'(r_sel + 2'd1) : r_ptr;

  rr_pick4 u_pick (
    .req   (w_pickReq),
    .ptr   (w_pickPtr),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef MUX_ARB_LOCK_EN
  localparam int CntW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

  logic [CntW-1:0] r_lockCnt;

  assign w_keep = lock[r_sel] && req[r_sel] && (r_lockCnt < CntW'(MAX_LOCK - 1));

  // Counter survives only a stall; any rotation, drop or idle cycle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lockCnt <= '0;
    end else if (w_xfer && w_keep) begin
      r_lockCnt <= r_lockCnt + CntW'(1);
    end else if (!w_stall) begin
      r_lockCnt <= '0;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= SEL_A;
      r_sel   <= SEL_A;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_idx;
            r_gnt   <= sel2onehot(w_idx);
          end else begin
            r_gnt   <= '0;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            if (!w_keep) begin
              r_ptr <= sel_t'(r_sel + 2'd1);
              r_sel <= w_idx;
              r_gnt <= sel2onehot(w_idx);
            end
          end else if (!req[r_sel]) begin
            // Requester withdrew without a transfer: release without touching the pointer.
            r_state <= IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_data = '0;
    if (w_valid) begin
      case (r_sel)
        SEL_A:   w_data = data_a;
        SEL_B:   w_data = data_b;
        SEL_C:   w_data = data_c;
        default: w_data = data_d;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign s1        = r_sel[1];
  assign s2        = r_sel[0];
  assign out_valid = w_valid;
  assign out_data  = w_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected transfers are queued as stimulus is driven
// and popped whenever the DUT completes a valid/ready handshake.
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int WIDTH = 4;
   localparam logic [WIDTH-1:0] DA = 4'h3;
   localparam logic [WIDTH-1:0] DB = 4'h5;
   localparam logic [WIDTH-1:0] DC = 4'h9;
   localparam logic [WIDTH-1:0] DD = 4'hC;

   typedef struct packed {
      logic [3:0]       gnt;
      logic [1:0]       sel;
      logic [WIDTH-1:0] data;
   } xfer_t;

   logic             clock = 1'b0;
   logic             rst_n;
   logic [3:0]       req;
   logic [WIDTH-1:0] data_a, data_b, data_c, data_d;
`ifdef MUX_ARB_LOCK_EN
   logic [3:0]       lock;
`endif
   logic [3:0]       gnt;
   logic             s1, s2;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   xfer_t expQ[$];
   xfer_t monExp;
   int    checks = 0;
   int    errors = 0;
   int    pops = 0;
   int    p0;

   mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_LOCK(4)) dut (
      .clk       (clock),
      .rst_n     (rst_n),
      .req       (req),
      .data_a    (data_a),
      .data_b    (data_b),
      .data_c    (data_c),
      .data_d    (data_d),
`ifdef MUX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .s1        (s1),
      .s2        (s2),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic expectState(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic [WIDTH-1:0] d);
      #1;
      checkOutput(tag, {gnt, s1, s2, out_valid, out_data}, {g, s, v, d});
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic rdy);
      req       = r;
      out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic xfer_t expOf(input int r);
      xfer_t e;
      e.gnt = 4'b0001 << r;
      e.sel = 2'(r);
      case (r)
         0:       e.data = DA;
         1:       e.data = DB;
         2:       e.data = DC;
         default: e.data = DD;
      endcase
      return e;
   endfunction

   // Every completed handshake must match the oldest queued expectation.
   always @(negedge clock) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checkOutput("xferQueued", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("xfer", {gnt, s1, s2, out_data}, monExp);
            pops++;
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence.
   initial begin
      rst_n  = 1'b0;
      data_a = DA; data_b = DB; data_c = DC; data_d = DD;
`ifdef MUX_ARB_LOCK_EN
      lock = 4'b0000;
`endif
      applyStimulus(4'b0000, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      expectState("reset", 4'b0000, 2'b00, 1'b0, '0);

      applyStimulus(4'b0100, 1'b0);
      rst_n = 1'b1;
      tick();
      expectState("grantC", 4'b0100, 2'b10, 1'b1, DC);
      tick();
      tick();
      expectState("stallC", 4'b0100, 2'b10, 1'b1, DC);
      #2 rst_n = 1'b0;
      expectState("asyncReset", 4'b0000, 2'b00, 1'b0, '0);
      tick();
      rst_n = 1'b1;
      tick();
      expectState("regrantC", 4'b0100, 2'b10, 1'b1, DC);

      expQ.push_back(expOf(2));
      applyStimulus(4'b0100, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b0);
      expectState("cReleased", 4'b0100, 2'b10, 1'b0, '0);
      tick();
      expectState("idleHoldSel", 4'b0000, 2'b10, 1'b0, '0);

      // Pointer now sits at d; a lone d transfer wraps it to a.
      expQ.push_back(expOf(3));
      applyStimulus(4'b1000, 1'b1);
      tick();
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();

      p0 = pops;
      expQ.push_back(expOf(0));
      expQ.push_back(expOf(3));
      applyStimulus(4'b1001, 1'b1);
      tick();
      expectState("fairA", 4'b0001, 2'b00, 1'b1, DA);
      tick();
      applyStimulus(4'b1000, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();
      checkOutput("fairPops", 32'(pops - p0), 32'd2);

      // Back-to-back rotation from pointer a with everyone requesting.
      p0 = pops;
      expQ.push_back(expOf(0));
      expQ.push_back(expOf(1));
      expQ.push_back(expOf(2));
      expQ.push_back(expOf(3));
      expQ.push_back(expOf(0));
      applyStimulus(4'b1111, 1'b1);
      repeat (6) tick();
      applyStimulus(4'b0000, 1'b0);
      tick();
      checkOutput("b2bPops", 32'(pops - p0), 32'd5);
      expectState("b2bIdle", 4'b0000, 2'b01, 1'b0, '0);

      // Stalled grant to b stays frozen, then one transfer.
      applyStimulus(4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expectState("stallB", 4'b0010, 2'b01, 1'b1, DB);
      end
      expQ.push_back(expOf(1));
      applyStimulus(4'b0010, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();
      expectState("idleAfterB", 4'b0000, 2'b01, 1'b0, '0);

      applyStimulus(4'b0101, 1'b0);
      tick();
      expectState("ptrAfterB", 4'b0100, 2'b10, 1'b1, DC);

      // Withdrawn request: valid falls at once, pointer untouched.
      applyStimulus(4'b0000, 1'b0);
      expectState("dropValid", 4'b0100, 2'b10, 1'b0, '0);
      tick();
      expectState("dropIdle", 4'b0000, 2'b10, 1'b0, '0);
      applyStimulus(4'b0110, 1'b0);
      tick();
      expectState("ptrAfterDrop", 4'b0100, 2'b10, 1'b1, DC);

      expQ.push_back(expOf(2));
      expQ.push_back(expOf(1));
      applyStimulus(4'b0110, 1'b1);
      tick();
      applyStimulus(4'b0010, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b0);
      tick();

`ifdef MUX_ARB_LOCK_EN
      // Locked a keeps four transfers, then b gets a turn; second round proves the count restarted.
      for (int round = 0; round < 2; round++) begin
         p0 = pops;
         repeat (4) expQ.push_back(expOf(0));
         expQ.push_back(expOf(1));
         lock = 4'b0001;
         applyStimulus(4'b0011, 1'b1);
         repeat (5) tick();
         applyStimulus(4'b0010, 1'b1);
         tick();
         applyStimulus(4'b0000, 1'b0);
         lock = 4'b0000;
         tick();
         checkOutput("lockPops", 32'(pops - p0), 32'd5);
      end
`endif

      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1 select datapath. Four requesters compete for a single output channel; the block grants one at a time, drives the mux select pair `s1`/`s2`, and presents the selected requester's data on a valid/ready output handshake. It sits between the requester-side logic and the downstream consumer, replacing static select wiring with fair, registered arbitration.

## Interface
- `WIDTH`, default 1: data width per requester and output.
- `MAX_LOCK`, default 4: maximum consecutive locked transfers per grant. Only used when `MUX_ARB_LOCK_EN` is defined.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset. Asserts immediately; deassertion is synchronous to `clk`.
- `req`, input, 4: request vector. Bit 0 is a, bit 1 is b, bit 2 is c, bit 3 is d.
- `data_a`, `data_b`, `data_c`, `data_d`, input, WIDTH each: requester data.
- `lock`, input, 4: per-requester lock. Present only with `MUX_ARB_LOCK_EN`.
- `gnt`, output, 4: registered one-hot grant, or 0.
- `s1`, `s2`, output, 1 each: registered select. `{s1,s2}` = 00 selects a, 01 b, 10 c, 11 d.
- `out_valid`, output, 1: output data valid.
- `out_data`, output, WIDTH: selected data. Forced to 0 when `out_valid` is 0.
- `out_ready`, input, 1: downstream accepts.

## Operation
- FSM has two states: IDLE and GRANT. Pointer `ptr` (2 bits) names the highest-priority requester for the next arbitration.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching `ptr`, `ptr+1`, ... (mod 4).
  - Register `gnt` and `{s1,s2}` for the winner, then go to GRANT.
  - Otherwise stay in IDLE; `gnt` = 0.
- **GRANT:**
  - `out_valid` = `req[sel]`.
  - `out_data` = `data_<sel>` when valid.
  - A transfer occurs when `out_valid` and `out_ready` are both 1.
- **On transfer:**
  - `ptr` becomes `sel+1` (mod 4).
  - Re-arbitrate in the same cycle from the new `ptr` using current `req` with the granted bit masked.
  - If there is a winner, stay in GRANT with the new grant, giving back-to-back transfers with no bubble.
  - Otherwise go to IDLE with `gnt` = 0.
  - Exception: if the granted bit is the only request, it may re-win (masking applies only when another request exists).
- **Requester rules:**
  - A requester holds `req` until it sees a transfer.
  - If it drops `req` while granted without a transfer, `out_valid` falls that cycle, and next cycle the block returns to IDLE with `ptr` unchanged.
- **Selects:** `s1`/`s2` hold their last value in IDLE; only `gnt` clears.
- **Reset:**
  - State IDLE, `ptr` = 0, `gnt` = 0, `s1` = `s2` = 0, `out_valid` = 0, `out_data` = 0, lock counter = 0.
  - Reset mid-GRANT aborts the transfer; nothing is retained.

## Timing
- Request to grant: 1 cycle from IDLE (`req` sampled at edge N, `gnt`/`out_valid` high after edge N).
- Grant to grant on transfer: 0 bubble cycles when other requests are pending.
- `out_valid` and `out_data` are combinational from registered `sel` and live `req`/data. There is no combinational path from `out_ready` to `out_valid`.
- Stall: while `out_ready` = 0, `gnt`, `s1`/`s2` and `ptr` are frozen.
- Simultaneous requests: the winner is strictly by rotation from `ptr`. Worst-case wait is 3 transfers.

## Configuration
- Macro: `MUX_ARB_LOCK_EN`.
- **Defined:**
  - `lock` port exists.
  - On a transfer with `lock[sel]` and `req[sel]` both 1, and lock count < `MAX_LOCK`−1, the grant is kept, `ptr` is not advanced, and the count increments.
  - Otherwise normal rotation applies and the count clears.
  - The count also clears on any grant change or on return to IDLE.
- **Not defined:** no `lock` port, no counter; every transfer rotates.

## Structure
- Package `mux_arb_pkg`:
  - `NUM_REQ` = 4.
  - `sel_t` (2-bit select typedef).
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Select encoding constants `SEL_A` through `SEL_D`.
- Sub-module `rr_pick4`:
  - Combinational rotating priority picker.
  - Inputs: `req[3:0]`, `ptr`.
  - Outputs: `found`, `idx` (sel_t).
  - Instantiated once; the same picker serves both IDLE and post-transfer arbitration.

## Test plan
- Reset mid-GRANT (`req`=0100, no ready) → all outputs 0 immediately; after release with `req`=0100, grant goes to c (`gnt`=0100, `{s1,s2}`=10).
- `req`=1111, `out_ready`=1 constant, `data_a`..`data_d`=0,1,0,1 → grant order a,b,c,d,a; `out_data` 0,1,0,1,0; one transfer per cycle after the first grant.
- `req`=0010 only, `out_ready`=0 for 3 cycles then 1 → `gnt`=0010 and `{s1,s2}`=01 stable during the stall; `out_valid` high throughout; single transfer; then IDLE with `ptr`=2.
- Stalled grant to b, then `req[1]` dropped → `out_valid` falls the same cycle; next cycle IDLE, `gnt`=0, `ptr` still at its old value.
- Fairness: after a transfer from d, `req`=1001 → a granted before d (`ptr` wraps to 0).
- With `MUX_ARB_LOCK_EN`, `MAX_LOCK`=4, `req`=0011, `lock`=0001, `out_ready`=1 → a, a, a, a, b; lock count clears after the forced release.
